// File: rtl/lake_config_loader.sv
// Config loader for lakespec: addr/data writes build a shadow config word; a commit copies it to
// cfg_out, holds flush for FLUSH_CYCLES, then raises cfg_valid. Optional readback: CFG_READBACK_EN.
module lake_config_loader #(
    parameter int CFG_WIDTH    = 550,
    parameter int WORD_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] config_addr,
    input  logic [WORD_WIDTH-1:0] config_data,
    input  logic                  config_write,
    input  logic                  config_read,
    output logic                  config_ready,
    output logic [WORD_WIDTH-1:0] config_rd_data,
    output logic                  config_rd_valid,
    output logic [CFG_WIDTH-1:0]  cfg_out,
    output logic                  cfg_valid,
    output logic                  flush,
    output logic                  cfg_err
);

    localparam int NUM_WORDS = (CFG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CTRL_ADDR = NUM_WORDS;
    localparam int LAST_W    = CFG_WIDTH - (NUM_WORDS - 1) * WORD_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W     = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CFG_WIDTH-1:0]   shadow;
    logic [NUM_WORDS-1:0]   mask;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [IDX_W-1:0]       widx;
    logic                   wr_acc;
    logic                   wr_word;
    logic                   wr_ctrl;
    logic                   wr_range_err;
    logic                   commit_req;
    logic                   mask_full;
    logic                   commit;
    logic                   rd_err;
    logic                   err_set;

    // Address decode; only the low index bits select a word once range is known.
    assign widx         = config_addr[IDX_W-1:0];
    assign wr_acc       = config_write && config_ready;
    assign wr_word      = wr_acc && (config_addr <  ADDR_WIDTH'(NUM_WORDS));
    assign wr_ctrl      = wr_acc && (config_addr == ADDR_WIDTH'(CTRL_ADDR));
    assign wr_range_err = wr_acc && (config_addr >  ADDR_WIDTH'(CTRL_ADDR));
    assign commit_req   = wr_ctrl && config_data[0];
    assign mask_full    = &mask;
    assign commit       = commit_req && mask_full;
    assign cnt_next     = cnt + CNT_W'(1);

    assign err_set = (config_write && !config_ready)
                   || rd_err
                   || wr_range_err
                   || (commit_req && !mask_full);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wr_word) begin
                    state_next = LOAD;
                end
            end
            LOAD, RUN: begin
                if (commit) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_next == CNT_W'(FLUSH_CYCLES)) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        flush        = 1'b0;
        cfg_valid    = 1'b0;
        config_ready = 1'b1;
        case (state)
            FLUSH: begin
                flush        = 1'b1;
                config_ready = 1'b0;
            end
            RUN:     cfg_valid = 1'b1;
            default: ;
        endcase
    end

    // Shadow/active datapath, flush counter and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow  <= '0;
            cfg_out <= '0;
            mask    <= '0;
            cnt     <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (commit) begin
                cfg_out <= shadow;
                mask    <= '0;
                cnt     <= '0;
            end else if (wr_word) begin
                for (int i = 0; i < NUM_WORDS - 1; i++) begin
                    if (widx == IDX_W'(i)) begin
                        shadow[i*WORD_WIDTH +: WORD_WIDTH] <= config_data;
                    end
                end
                // The top word is partial; bits above CFG_WIDTH are discarded.
                if (widx == IDX_W'(NUM_WORDS - 1)) begin
                    shadow[CFG_WIDTH-1 -: LAST_W] <= config_data[LAST_W-1:0];
                end
                mask <= mask | (NUM_WORDS'(1) << widx);
            end
            if (state == FLUSH) begin
                cnt <= cnt_next;
            end
            if (err_set) begin
                cfg_err <= 1'b1;
            end
        end
    end

`ifdef CFG_READBACK_EN
    logic                  rd_acc;
    logic [WORD_WIDTH-1:0] rd_word;

    assign rd_acc = config_read && config_ready;
    assign rd_err = config_read && !config_ready;

    // Reads sample the current shadow, so a same-cycle write is not visible yet.
    always_comb begin
        rd_word = '0;
        if (config_addr < ADDR_WIDTH'(NUM_WORDS)) begin
            for (int i = 0; i < NUM_WORDS - 1; i++) begin
                if (widx == IDX_W'(i)) begin
                    rd_word = shadow[i*WORD_WIDTH +: WORD_WIDTH];
                end
            end
            if (widx == IDX_W'(NUM_WORDS - 1)) begin
                rd_word = WORD_WIDTH'(shadow[CFG_WIDTH-1 -: LAST_W]);
            end
        end else if (config_addr == ADDR_WIDTH'(CTRL_ADDR)) begin
            rd_word = WORD_WIDTH'({cfg_valid, cfg_err});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            config_rd_data  <= '0;
            config_rd_valid <= 1'b0;
        end else begin
            config_rd_valid <= rd_acc;
            config_rd_data  <= rd_acc ? rd_word : '0;
        end
    end
`else
    logic unused_read;

    assign unused_read     = config_read;
    assign rd_err          = 1'b0;
    assign config_rd_data  = '0;
    assign config_rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lake_config_loader.sv
// Self-checking bench for lake_config_loader: scoreboards for committed configs and readback data,
// plus directed checks on flush timing, error cases and reset behaviour.
module tb_lake_config_loader;

    localparam int CW   = 550;
    localparam int WW   = 32;
    localparam int AW   = 32;
    localparam int FC   = 10;
    localparam int NW   = 18;
    localparam int CTRL = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] config_addr;
    logic [WW-1:0] config_data;
    logic          config_write;
    logic          config_read;
    logic          config_ready;
    logic [WW-1:0] config_rd_data;
    logic          config_rd_valid;
    logic [CW-1:0] cfg_out;
    logic          cfg_valid;
    logic          flush;
    logic          cfg_err;

    lake_config_loader #(
        .CFG_WIDTH(CW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .config_addr(config_addr), .config_data(config_data),
        .config_write(config_write), .config_read(config_read),
        .config_ready(config_ready), .config_rd_data(config_rd_data),
        .config_rd_valid(config_rd_valid), .cfg_out(cfg_out),
        .cfg_valid(cfg_valid), .flush(flush), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [CW-1:0] m_shadow;
    logic [CW-1:0] cfg_q[$];
    logic [WW-1:0] rd_q[$];
    logic          prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: a committed config appears when cfg_valid rises; readback data when rd_valid is high.
    always @(negedge clk) begin
        if (cfg_valid && !prev_valid) begin
            if (cfg_q.size() == 0) chk("cfg_unexpected", 1, 0);
            else                   chk("cfg_sb", cfg_out, cfg_q.pop_front());
        end
        prev_valid <= cfg_valid;
        if (config_rd_valid) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else                  chk("rd_sb", {{(CW-WW){1'b0}}, config_rd_data}, {{(CW-WW){1'b0}}, rd_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic model_wr(input int a, input logic [WW-1:0] d);
        if (a < NW - 1)       m_shadow[a*WW +: WW] = d;
        else if (a == NW - 1) m_shadow[CW-1 -: 6] = d[5:0];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_shadow = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_write(input int a, input logic [WW-1:0] d);
        config_addr  = AW'(a);
        config_data  = d;
        config_write = 1'b1;
        @(posedge clk);
        #1 config_write = 1'b0;
    endtask

    task automatic write_word(input int a, input logic [WW-1:0] d);
        do_write(a, d);
        model_wr(a, d);
    endtask

    task automatic do_read(input int a, input logic [WW-1:0] exp);
        config_addr = AW'(a);
        config_read = 1'b1;
        @(posedge clk);
        #1 config_read = 1'b0;
`ifdef CFG_READBACK_EN
        rd_q.push_back(exp);
        @(negedge clk);
        chk("rd_valid", config_rd_valid, 1);
`else
        @(negedge clk);
        chk("rd_off_valid", config_rd_valid, 0);
        chk("rd_off_data", config_rd_data, 0);
        if (exp === 'x) chk("rd_off_x", 1, 0);
`endif
    endtask

    task automatic do_wr_rd(input int a, input logic [WW-1:0] d, input logic [WW-1:0] exp);
        config_addr  = AW'(a);
        config_data  = d;
        config_write = 1'b1;
        config_read  = 1'b1;
        @(posedge clk);
        #1 config_write = 1'b0;
        config_read = 1'b0;
        model_wr(a, d);
`ifdef CFG_READBACK_EN
        rd_q.push_back(exp);
        @(negedge clk);
        chk("wrrd_valid", config_rd_valid, 1);
`else
        @(negedge clk);
        chk("wrrd_off_valid", config_rd_valid, 0);
        if (exp === 'x) chk("wrrd_off_x", 1, 0);
`endif
    endtask

    // Called in the cycle after a commit edge; counts flush cycles and the cfg_valid-low cycles within.
    task automatic measure_flush(input string tag, input int exp);
        int n  = 0;
        int nv = 0;
        for (int k = 0; k < FC + 6; k++) begin
            @(negedge clk);
            if (!flush) break;
            n++;
            if (!cfg_valid && !config_ready) nv++;
        end
        chk({tag, "_flush_len"}, n, exp);
        chk({tag, "_valid_low"}, nv, exp);
        chk({tag, "_valid_after"}, cfg_valid, 1);
        chk({tag, "_ready_after"}, config_ready, 1);
    endtask

    initial begin
        config_addr  = '0;
        config_data  = '0;
        config_write = 1'b0;
        config_read  = 1'b0;
        m_shadow     = '0;
        do_reset();

        @(negedge clk);
        chk("rst_cfg_out", cfg_out, 0);
        chk("rst_cfg_valid", cfg_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_ready", config_ready, 1);
        chk("rst_rd_valid", config_rd_valid, 0);
        chk("rst_rd_data", config_rd_data, 0);

        // Full load and commit
        for (int i = 0; i < NW; i++) write_word(i, 32'h1000_0000 + i);
        cfg_q.push_back(m_shadow);
        do_write(CTRL, 32'h1);
        measure_flush("c1", FC);
        chk("c1_word0", cfg_out[31:0], 32'h1000_0000);
        chk("c1_word17", cfg_out[549:544], 6'h11);
        chk("c1_err", cfg_err, 0);

        // Readback, including same-cycle write+read and the partial/ctrl/out-of-range words
        write_word(5, 32'hA5A5_0001);
        do_read(5, 32'hA5A5_0001);
        do_wr_rd(5, 32'h2, 32'hA5A5_0001);
        do_read(5, 32'h2);
        do_read(17, 32'h11);
        do_read(CTRL, 32'h2);
        do_read(19, 32'h0);

        // Shadow write in RUN leaves the active config alone
        write_word(3, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("run_cfg_word3", cfg_out[127:96], 32'h1000_0003);
        chk("run_cfg_valid", cfg_valid, 1);
        for (int i = 0; i < NW; i++) write_word(i, (i == 3) ? 32'hDEAD_BEEF : 32'h2000_0000 + i);
        cfg_q.push_back(m_shadow);
        do_write(CTRL, 32'h1);
        measure_flush("c2", FC);
        chk("c2_word3", cfg_out[127:96], 32'hDEAD_BEEF);
        chk("c2_err", cfg_err, 0);

        // Write during flush is dropped and does not stretch the window
        for (int i = 0; i < NW; i++) write_word(i, 32'h3000_0000 + i);
        cfg_q.push_back(m_shadow);
        do_write(CTRL, 32'h1);
        do_write(5, 32'hFFFF_FFFF);
        measure_flush("c3", FC - 1);
        chk("flushwr_err", cfg_err, 1);
        do_read(5, 32'h3000_0005);

        // No-op control write, then out-of-range write
        do_reset();
        @(negedge clk);
        chk("rst2_err", cfg_err, 0);
        chk("rst2_cfg_out", cfg_out, 0);
        do_write(CTRL, 32'h0);
        @(negedge clk);
        chk("noop_err", cfg_err, 0);
        chk("noop_flush", flush, 0);
        do_write(19, 32'h1234_5678);
        @(negedge clk);
        chk("oor_err", cfg_err, 1);
        chk("oor_flush", flush, 0);
        do_read(0, 32'h0);

        // Incomplete commit is refused; completing the mask then commits
        do_reset();
        for (int i = 0; i < NW - 1; i++) write_word(i, 32'h1000_0000 + i);
        do_write(CTRL, 32'h1);
        begin
            int nf = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (flush) nf++;
            end
            chk("inc_flush_cnt", nf, 0);
        end
        chk("inc_err", cfg_err, 1);
        chk("inc_cfg_valid", cfg_valid, 0);
        chk("inc_ready", config_ready, 1);
        write_word(NW - 1, 32'h1000_0011);
        do_write(CTRL, 32'h1);
        @(negedge clk);
        chk("late_commit_flush", flush, 1);

        // Reset asserted during the 4th flush cycle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst4_pre_flush", flush, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_shadow = '0;
        @(negedge clk);
        chk("rst4_flush", flush, 0);
        chk("rst4_cfg_out", cfg_out, 0);
        chk("rst4_cfg_valid", cfg_valid, 0);
        chk("rst4_err", cfg_err, 0);
        chk("rst4_ready", config_ready, 1);

        repeat (2) @(negedge clk);
        chk("cfg_sb_drain", cfg_q.size(), 0);
        chk("rd_sb_drain", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
